// File: rtl/bcd_serial_alu.sv
// Digit-serial packed-BCD add/subtract unit: one decimal digit per clock through a
// single shared digit adder, with sign/magnitude result and overflow/invalid flags.
module bcd_serial_alu #(
   parameter int DIGITS = 4
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  neg,
   output logic                  overflow,
   output logic                  invalid
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CHECK  = 3'd1;
   localparam logic [2:0] ADD    = 3'd2;
   localparam logic [2:0] NEGATE = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   // Single-digit BCD add with decimal correction; returns {carry, digit}.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                                input logic cin);
      logic [4:0] bin;
      bin = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      if (bin > 5'd9) begin
         return {1'b1, bin[3:0] + 4'd6};
      end else begin
         return {1'b0, bin[3:0]};
      end
   endfunction

   logic [2:0]            state_r;
   logic [4*DIGITS-1:0]   a_r;
   logic [4*DIGITS-1:0]   b_r;
   logic                  op_r;
   logic [IDX_W-1:0]      idx_r;
   logic                  carry_r;
   logic                  busy_r;
   logic                  done_r;
   logic [4*DIGITS-1:0]   result_r;
   logic                  neg_r;
   logic                  overflow_r;
   logic                  invalid_r;

   logic [3:0]            x_s;
   logic [3:0]            y_s;
   logic [4:0]            digit_s;
   logic                  any_bad_s;
   logic                  last_s;

   assign busy     = busy_r;
   assign done     = done_r;
   assign result   = result_r;
   assign neg      = neg_r;
   assign overflow = overflow_r;
   assign invalid  = invalid_r;

   assign last_s = (idx_r == IDX_W'(DIGITS - 1));

   // Operand mux feeding the one shared digit adder (ADD vs NEGATE).
   always_comb begin
      x_s = 4'd0;
      y_s = 4'd0;
      if (state_r == NEGATE) begin
         x_s = 4'd9 - result_r[idx_r*4 +: 4];
         y_s = 4'd0;
      end else begin
         x_s = a_r[idx_r*4 +: 4];
         y_s = op_r ? (4'd9 - b_r[idx_r*4 +: 4]) : b_r[idx_r*4 +: 4];
      end
      digit_s = bcd_digit_add(x_s, y_s, carry_r);
   end

   // Scan the latched operands for non-decimal digits.
   always_comb begin
      any_bad_s = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((a_r[4*i +: 4] > 4'd9) || (b_r[4*i +: 4] > 4'd9)) begin
            any_bad_s = 1'b1;
         end else begin
            any_bad_s = any_bad_s;
         end
      end
   end

   // Control FSM, digit sequencing and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r    <= IDLE;
         a_r        <= '0;
         b_r        <= '0;
         op_r       <= 1'b0;
         idx_r      <= '0;
         carry_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         result_r   <= '0;
         neg_r      <= 1'b0;
         overflow_r <= 1'b0;
         invalid_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r        <= a;
                  b_r        <= b;
                  op_r       <= op;
                  result_r   <= '0;
                  neg_r      <= 1'b0;
                  overflow_r <= 1'b0;
                  invalid_r  <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= CHECK;
               end
            end
            CHECK: begin
               if (any_bad_s) begin
                  invalid_r <= 1'b1;
                  result_r  <= '0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  idx_r   <= '0;
                  carry_r <= op_r;
                  state_r <= ADD;
               end
            end
            ADD: begin
               result_r[idx_r*4 +: 4] <= digit_s[3:0];
               carry_r                <= digit_s[4];
               if (!last_s) begin
                  idx_r <= idx_r + IDX_W'(1);
               end else if (!op_r || digit_s[4]) begin
                  // No end-around carry on subtract means A<B: recomplement.
                  overflow_r <= !op_r && digit_s[4];
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  neg_r   <= 1'b1;
                  idx_r   <= '0;
                  carry_r <= 1'b1;
                  state_r <= NEGATE;
               end
            end
            NEGATE: begin
               result_r[idx_r*4 +: 4] <= digit_s[3:0];
               carry_r                <= digit_s[4];
               if (last_s) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed bench for bcd_serial_alu: DIGITS=1, 4 and 8 instances sharing clock and reset.
module tb_bcd_serial_alu;

   logic clk = 1'b0;
   logic rst_n;
   always #10 clk = ~clk;

   logic        s1, o1, bz1, dn1, ng1, ov1, iv1;
   logic [3:0]  a1, b1, r1;
   logic        s4, o4, bz4, dn4, ng4, ov4, iv4;
   logic [15:0] a4, b4, r4;
   logic        s8, o8, bz8, dn8, ng8, ov8, iv8;
   logic [31:0] a8, b8, r8;

   int errors = 0;
   int checks = 0;

   bcd_serial_alu #(.DIGITS(1)) dut1 (.CLOCK_50(clk), .RESET_N(rst_n), .start(s1), .op(o1),
      .a(a1), .b(b1), .busy(bz1), .done(dn1), .result(r1), .neg(ng1), .overflow(ov1), .invalid(iv1));
   bcd_serial_alu #(.DIGITS(4)) dut4 (.CLOCK_50(clk), .RESET_N(rst_n), .start(s4), .op(o4),
      .a(a4), .b(b4), .busy(bz4), .done(dn4), .result(r4), .neg(ng4), .overflow(ov4), .invalid(iv4));
   bcd_serial_alu #(.DIGITS(8)) dut8 (.CLOCK_50(clk), .RESET_N(rst_n), .start(s8), .op(o8),
      .a(a8), .b(b8), .busy(bz8), .done(dn8), .result(r8), .neg(ng8), .overflow(ov8), .invalid(iv8));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic opv,
                        input logic [31:0] av, input logic [31:0] bv);
      case (sel)
         1: begin s1 = st; o1 = opv; a1 = av[3:0];  b1 = bv[3:0];  end
         4: begin s4 = st; o4 = opv; a4 = av[15:0]; b4 = bv[15:0]; end
         default: begin s8 = st; o8 = opv; a8 = av; b8 = bv; end
      endcase
   endtask

   // {done, busy, neg, overflow, invalid, result}
   function automatic logic [36:0] observe(input int sel);
      case (sel)
         1: return {dn1, bz1, ng1, ov1, iv1, 28'h0, r1};
         4: return {dn4, bz4, ng4, ov4, iv4, 16'h0, r4};
         default: return {dn8, bz8, ng8, ov8, iv8, r8};
      endcase
   endfunction

   task automatic run_op(input string tag, input int sel, input logic opv,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input logic exp_neg,
                         input logic exp_ovf, input logic exp_inv,
                         input int exp_lat, input bit mid_pulse);
      logic [36:0] obs;
      int lat;
      bit seen;
      @(negedge clk);
      drive(sel, 1'b1, opv, av, bv);
      @(posedge clk);
      lat  = 1;
      seen = 1'b0;
      obs  = '0;
      while (!seen && lat <= 60) begin
         @(negedge clk);
         obs = observe(sel);
         if (obs[36]) begin
            seen = 1'b1;
         end else begin
            if (mid_pulse && lat == 2) drive(sel, 1'b1, opv, 32'h99999999, bv);
            else drive(sel, 1'b0, opv, av, bv);
            @(posedge clk);
            lat++;
         end
      end
      drive(sel, 1'b0, opv, av, bv);
      check_eq({tag, " done"}, 32'(seen), 32'd1);
      if (seen) begin
         check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
         check_eq({tag, " result"}, obs[31:0], exp_res);
         check_eq({tag, " neg"}, 32'(obs[34]), 32'(exp_neg));
         check_eq({tag, " overflow"}, 32'(obs[33]), 32'(exp_ovf));
         check_eq({tag, " invalid"}, 32'(obs[32]), 32'(exp_inv));
         check_eq({tag, " busy@done"}, 32'(obs[35]), 32'd0);
         @(negedge clk);
         obs = observe(sel);
         check_eq({tag, " held"}, obs[31:0], exp_res);
         check_eq({tag, " done pulse"}, 32'(obs[36]), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst busy", 32'(bz4), 32'd0);
      check_eq("rst done", 32'(dn4), 32'd0);
      check_eq("rst result", 32'(r4), 32'h0);
      check_eq("rst flags", 32'({ng4, ov4, iv4}), 32'd0);
      rst_n = 1'b1;

      // Reset pulse in the middle of an ADD pass
      @(negedge clk);
      drive(4, 1'b1, 1'b0, 32'h1234, 32'h4321);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b0, 1'b0, 32'h1234, 32'h4321);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("midadd busy", 32'(bz4), 32'd1);
      check_eq("midadd partial", 32'(r4), 32'h0055);
      rst_n = 1'b0;
      #1;
      check_eq("midrst busy", 32'(bz4), 32'd0);
      check_eq("midrst result", 32'(r4), 32'h0);
      check_eq("midrst flags", 32'({dn4, ng4, ov4, iv4}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after rst", 4, 1'b0, 32'h1234, 32'h4321, 32'h5555, 1'b0, 1'b0, 1'b0, 6, 1'b0);

      run_op("add 42+58",   4, 1'b0, 32'h0042, 32'h0058, 32'h0100, 1'b0, 1'b0, 1'b0, 6, 1'b0);
      run_op("add ovf",     4, 1'b0, 32'h9999, 32'h0001, 32'h0000, 1'b0, 1'b1, 1'b0, 6, 1'b0);
      run_op("add zero",    4, 1'b0, 32'h0000, 32'h0000, 32'h0000, 1'b0, 1'b0, 1'b0, 6, 1'b0);
      run_op("sub neg",     4, 1'b1, 32'h1234, 32'h5678, 32'h4444, 1'b1, 1'b0, 1'b0, 10, 1'b0);
      run_op("sub equal",   4, 1'b1, 32'h0500, 32'h0500, 32'h0000, 1'b0, 1'b0, 1'b0, 6, 1'b0);
      run_op("invalid",     4, 1'b0, 32'h12A4, 32'h0001, 32'h0000, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      run_op("start busy",  4, 1'b0, 32'h1111, 32'h2222, 32'h3333, 1'b0, 1'b0, 1'b0, 6, 1'b1);

      run_op("d1 9-0",      1, 1'b1, 32'h9, 32'h0, 32'h9, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      run_op("d1 0-9",      1, 1'b1, 32'h0, 32'h9, 32'h9, 1'b1, 1'b0, 1'b0, 4, 1'b0);
      run_op("d1 5+7",      1, 1'b0, 32'h5, 32'h7, 32'h2, 1'b0, 1'b1, 1'b0, 3, 1'b0);
      run_op("d1 invalid",  1, 1'b0, 32'hB, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

      run_op("d8 ovf",      8, 1'b0, 32'h99999999, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 10, 1'b0);
      run_op("d8 sub neg",  8, 1'b1, 32'h12345678, 32'h87654321, 32'h75308643, 1'b1, 1'b0, 1'b0, 18, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Parametrised, digit-serial BCD add/subtract unit for the board-level calculator datapath. It accepts two DIGITS-wide packed-BCD operands and computes A+B or A−B one decimal digit per clock, using a single shared 4-bit BCD digit adder with decimal correction. Results are reported as sign plus magnitude, with overflow and invalid-digit flags. It replaces the fixed 2-digit combinational adder path and drives the existing 7-segment decode stage, which blanks on overflow or invalid input.

## Interface
- DIGITS, 4, number of BCD digits per operand and result (≥1)
- CLOCK_50  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = add, 1 = subtract (A−B); latched with start
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]; latched with start
- b  in  4*DIGITS  operand B, packed BCD; latched with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse, result/flags valid from this cycle
- result  out  4*DIGITS  packed-BCD magnitude, held until next accepted start
- neg  out  1  result is negative (subtract only)
- overflow  out  1  addition carry out of the most-significant digit
- invalid  out  1  a latched operand digit was >9

## Operation
- States: IDLE, CHECK, ADD, NEGATE, DONE.
- IDLE: when start=1, latch a, b, and op. Clear result and the flags. Go to CHECK. A start outside IDLE is ignored.
- CHECK (1 cycle): if any latched digit is >9, set invalid=1 and result=0, then go to DONE. Otherwise clear the digit index and set the carry to op. Go to ADD.
- ADD (DIGITS cycles, LSD first): compute digit i = A[i] + B'[i] + carry.
  - B'[i] = B[i] for add; B'[i] = 9−B[i] for subtract.
  - Decimal correction: if the binary sum is >9 (carry4 | s3&(s2|s1)), add 6 and set carry=1.
  - The result digit is written into result[i].
- After the last digit:
  - Add: overflow = final carry; result keeps the low DIGITS digits (sum mod 10^DIGITS). Go to DONE.
  - Subtract with carry=1: result ≥0, neg=0. Go to DONE.
  - Subtract with carry=0: result <0. Set neg=1, reset the index and set carry=1. Go to NEGATE.
- NEGATE (DIGITS cycles): result[i] = (9−result[i]) + carry, with decimal correction, giving 10^DIGITS − R. Go to DONE.
- DONE (1 cycle): done=1, busy=0 in this cycle. Go to IDLE. start is not accepted in the DONE cycle.
- Subtract never sets overflow. A zero difference gives neg=0.
- The digit adder is shared between ADD and NEGATE; no more than one instance exists.

## Timing
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE.
  - busy, done, neg, overflow, invalid = 0.
  - result = 0.
  - Latched operands and op = 0.
- Start accepted on edge E0. busy is high from E0 until the edge entering DONE.
- done pulse cycle, counted in edges after E0:
  - Invalid input: 2.
  - Add, or subtract with non-negative result: DIGITS+2.
  - Subtract with negative result: 2*DIGITS+2.
- result is partially updated during ADD/NEGATE. It is valid only from the done pulse onward, and is stable until the next accepted start.
- A start held high continuously restarts one cycle after DONE, i.e. from IDLE.

## Test plan
- Reset mid-ADD (DIGITS=4, 1234+4321, RESET_N low for 1 cycle at cycle 3) -> all outputs 0 immediately; a following start completes normally to 5555.
- Add, DIGITS=4: a=0x0042, b=0x0058, op=0 -> result=0x0100, neg=0, overflow=0, done at edge 6.
- Add overflow: a=0x9999, b=0x0001 -> result=0x0000, overflow=1, done at edge 6. Also 0x0000+0x0000 -> 0x0000, no flags.
- Subtract negative: a=0x1234, b=0x5678, op=1 -> result=0x4444, neg=1, done at edge 10. Subtract equal: 0x0500−0x0500 -> 0x0000, neg=0, done at edge 6.
- Invalid: a=0x12A4, b=0x0001 -> invalid=1, result=0, done at edge 2. A start pulsed while busy is ignored.
- DIGITS=1 and DIGITS=8 builds: 9−0 -> 9; 0−9 -> 9, neg=1; 99999999+1 -> 0, overflow=1. Verify done latency equals the formulas.
